// File: rtl/stream_accum_pkg.sv
// Shared definitions for the stream accumulator and its upstream FIFO.
//   DATA_W     : default word width
//   GROUP_DEF  : default number of words per full group
//   acc_state_t: ACC/OUT state encoding
package stream_accum_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned GROUP_DEF = 4;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } acc_state_t;

endpackage

// File: rtl/stream_accum.sv
// Sums GROUP upstream words (or a flushed partial group) and presents the
// result on a valid/ready output with a word count and an overflow flag.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_val/in_data/in_rdy: upstream word handshake (in_rdy from state only)
//   flush                : emit the current partial group if non-empty
//   out_val/out_data     : result handshake, sum modulo 2^W
//   out_cnt              : number of words in out_data
//   out_ovf              : a carry out of bit W-1 happened inside the group
//   out_rdy              : downstream accepts the result
module stream_accum
    import stream_accum_pkg::*;
#(
    parameter int unsigned W     = DATA_W,
    parameter int unsigned GROUP = GROUP_DEF,
    localparam int unsigned CW   = $clog2(GROUP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_val,
    input  logic [W-1:0]  in_data,
    output logic          in_rdy,
    input  logic          flush,
    output logic          out_val,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_cnt,
    output logic          out_ovf,
    input  logic          out_rdy
);

    acc_state_t    r_state,    w_state_nxt;
    logic [W-1:0]  r_acc,      w_acc_nxt;
    logic [CW-1:0] r_cnt,      w_cnt_nxt;
    logic          r_ovf,      w_ovf_nxt;
    logic          r_in_rdy,   w_in_rdy_nxt;
    logic          r_out_val,  w_out_val_nxt;
    logic [W-1:0]  r_out_data, w_out_data_nxt;
    logic [CW-1:0] r_out_cnt,  w_out_cnt_nxt;
    logic          r_out_ovf,  w_out_ovf_nxt;

    logic          w_accept;
    logic [W:0]    w_sum;
    logic [CW-1:0] w_cnt_inc;
    logic          w_emit;

    // Inline adder; the extra MSB is the carry out of bit W-1.
    assign w_accept  = (r_state == ST_ACC) && in_val;
    assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
    assign w_cnt_inc = r_cnt + CW'(1);

    // Leave ACC on the GROUP-th word, or on flush when the group is non-empty
    // (counting a word accepted in the same cycle).
    assign w_emit = (w_accept && (w_cnt_inc == CW'(GROUP)))
                 || (flush && (w_accept || (r_cnt != '0)));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_ovf_nxt      = r_ovf;
        w_in_rdy_nxt   = r_in_rdy;
        w_out_val_nxt  = r_out_val;
        w_out_data_nxt = r_out_data;
        w_out_cnt_nxt  = r_out_cnt;
        w_out_ovf_nxt  = r_out_ovf;

        case (r_state)
            ST_ACC: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[W-1:0];
                    w_cnt_nxt = w_cnt_inc;
                    w_ovf_nxt = r_ovf | w_sum[W];
                end
                if (w_emit) begin
                    w_state_nxt    = ST_OUT;
                    w_in_rdy_nxt   = 1'b0;
                    w_out_val_nxt  = 1'b1;
                    w_out_data_nxt = w_acc_nxt;
                    w_out_cnt_nxt  = w_cnt_nxt;
                    w_out_ovf_nxt  = w_ovf_nxt;
                end
            end
            ST_OUT: begin
                // Handoff cycle: clear everything, accept nothing this cycle.
                if (out_rdy) begin
                    w_state_nxt    = ST_ACC;
                    w_acc_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_ovf_nxt      = 1'b0;
                    w_in_rdy_nxt   = 1'b1;
                    w_out_val_nxt  = 1'b0;
                    w_out_data_nxt = '0;
                    w_out_cnt_nxt  = '0;
                    w_out_ovf_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_cnt  <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_in_rdy   <= w_in_rdy_nxt;
            r_out_val  <= w_out_val_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_out_ovf  <= w_out_ovf_nxt;
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign out_cnt  = r_out_cnt;
    assign out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_stream_accum.sv
// Directed bench for stream_accum: a group-sum reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_stream_accum;

    localparam int unsigned TW  = 32;
    localparam int unsigned TG  = 4;
    localparam int unsigned TCW = $clog2(TG + 1);
    localparam longint unsigned MODV = 64'h1_0000_0000;

    logic           clk;
    logic           reset;
    logic           in_val;
    logic [TW-1:0]  in_data;
    logic           in_rdy;
    logic           flush;
    logic           out_val;
    logic [TW-1:0]  out_data;
    logic [TCW-1:0] out_cnt;
    logic           out_ovf;
    logic           out_rdy;

    stream_accum #(.W(TW), .GROUP(TG)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .flush    (flush),
        .out_val  (out_val),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf),
        .out_rdy  (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unbounded running total of the group's words.
    // A carry out of bit W-1 occurred iff the true total reached 2^W.
    logic            m_hold;
    longint unsigned m_total;
    int              m_n;
    longint unsigned m_rdata;
    int              m_rcnt;
    logic            m_rovf;
    longint unsigned mq_data[$];

    always @(posedge clk or posedge reset) begin : model
        longint unsigned t;
        int n;
        if (reset) begin
            m_hold  <= 1'b0;
            m_total <= 0;
            m_n     <= 0;
            m_rdata <= 0;
            m_rcnt  <= 0;
            m_rovf  <= 1'b0;
        end else if (m_hold) begin
            if (out_rdy) begin
                mq_data.push_back(m_rdata);
                m_hold  <= 1'b0;
                m_total <= 0;
                m_n     <= 0;
            end
        end else begin
            t = m_total;
            n = m_n;
            if (in_val) begin
                t = t + longint'(in_data);
                n = n + 1;
            end
            if ((n == int'(TG)) || (flush && (n > 0))) begin
                m_hold  <= 1'b1;
                m_rdata <= t % MODV;
                m_rcnt  <= n;
                m_rovf  <= (t >= MODV);
            end
            m_total <= t;
            m_n     <= n;
        end
    end

    int n_cmp;
    int n_bad;
    int n_ov;
    longint unsigned dq_data[$];
    int              dq_cnt[$];
    logic            dq_ovf[$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: compare against the model at the falling edge, log handoffs,
    // then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        check("in_rdy",   longint'(in_rdy),   longint'(!m_hold));
        check("out_val",  longint'(out_val),  longint'(m_hold));
        check("out_data", longint'(out_data), m_hold ? longint'(m_rdata) : 0);
        check("out_cnt",  longint'(out_cnt),  m_hold ? longint'(m_rcnt) : 0);
        check("out_ovf",  longint'(out_ovf),  m_hold ? longint'(m_rovf) : 0);
        if (out_val) n_ov++;
        if (out_val && out_rdy) begin
            dq_data.push_back(longint'(out_data));
            dq_cnt.push_back(int'(out_cnt));
            dq_ovf.push_back(out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TW-1:0] d);
        in_val  = 1'b1;
        in_data = d;
        cyc();
    endtask

    task automatic group4(input logic [TW-1:0] a, b, c, d);
        send(a); send(b); send(c); send(d);
        in_val = 1'b0;
        cyc();
    endtask

    task automatic check_last(input string nm, input longint d, input int c, input logic o);
        if (dq_data.size() == 0) begin
            check({nm, "_present"}, 0, 1);
        end else begin
            check({nm, "_data"}, dq_data[$], d);
            check({nm, "_cnt"},  longint'(dq_cnt[$]), longint'(c));
            check({nm, "_ovf"},  longint'(dq_ovf[$]), longint'(o));
        end
    endtask

    int ov0;
    int lg0;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        n_ov    = 0;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        flush   = 1'b0;
        out_rdy = 1'b1;

        #12;
        check("rst_in_rdy",   longint'(in_rdy),   1);
        check("rst_out_val",  longint'(out_val),  0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_cnt",  longint'(out_cnt),  0);
        check("rst_out_ovf",  longint'(out_ovf),  0);
        #8;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic group, single-cycle out_val.
        ov0 = n_ov;
        group4(25, 35, 45, 55);
        check_last("g1", 160, 4, 1'b0);
        check("g1_model", longint'(mq_data[$]), 160);
        check("g1_val_cycles", longint'(n_ov - ov0), 1);

        // Back-pressure: result held while out_rdy is low.
        out_rdy = 1'b0;
        send(65); send(75); send(85); send(95);
        in_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_val",    longint'(out_val),  1);
            check("bp_data",   longint'(out_data), 320);
            check("bp_in_rdy", longint'(in_rdy),   0);
            cyc();
        end
        out_rdy = 1'b1;
        lg0 = dq_data.size();
        cyc();
        check("bp_handoff", longint'(dq_data.size() - lg0), 1);
        check("bp_rdy_after", longint'(in_rdy), 1);
        check("bp_val_after", longint'(out_val), 0);
        check_last("bp", 320, 4, 1'b0);

        // Overflow flag, then cleared for the next group.
        group4(32'hFFFF_FFFF, 2, 0, 0);
        check_last("ovf", 1, 4, 1'b1);
        check("ovf_model", longint'(mq_data[$]), 1);
        group4(1, 1, 1, 1);
        check_last("noovf", 4, 4, 1'b0);

        // Flush of a partial group, then flush with an empty group.
        send(96); send(97);
        in_val = 1'b0;
        flush  = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        check_last("flush", 193, 2, 1'b0);
        lg0 = dq_data.size();
        ov0 = n_ov;
        flush = 1'b1;
        cyc(); cyc();
        flush = 1'b0;
        cyc();
        check("empty_flush_log", longint'(dq_data.size() - lg0), 0);
        check("empty_flush_val", longint'(n_ov - ov0), 0);

        // Reset mid-group discards the partial sum.
        send(10); send(20); send(30);
        in_val = 1'b0;
        lg0 = dq_data.size();
        reset = 1'b1;
        #1;
        check("mid_rst_in_rdy",  longint'(in_rdy),  1);
        check("mid_rst_out_val", longint'(out_val), 0);
        #2;
        reset = 1'b0;
        cyc(); cyc();
        check("mid_rst_nores", longint'(dq_data.size() - lg0), 0);
        group4(1, 2, 3, 4);
        check_last("post_rst", 10, 4, 1'b0);

        // Flush in the same cycle as a word is accepted.
        send(5);
        in_val  = 1'b1;
        in_data = 7;
        flush   = 1'b1;
        cyc();
        in_val = 1'b0;
        flush  = 1'b0;
        cyc();
        check_last("flush_same", 12, 2, 1'b0);

        // Streaming: 3 groups in 15 cycles; words in the handoff cycle ignored.
        lg0 = dq_data.size();
        for (int i = 1; i <= 15; i++) begin
            send(TW'(i));
        end
        in_val = 1'b0;
        cyc(); cyc();
        check("stream_groups", longint'(dq_data.size() - lg0), 3);
        check_last("stream_last", 50, 4, 1'b0);
        check("stream_model", longint'(mq_data[$]), 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
